// File: rtl/round_trip_page_checker_if.sv
// Paired expected/actual byte streams between the page source, the decompressor and the checker.
// Both streams share one ready because the checker only ever consumes them in lockstep.
interface round_trip_page_checker_if #(
    parameter int LANES = 1
);
    logic [8*LANES-1:0] expData;
    logic               expValid;
    logic               expReady;
    logic [8*LANES-1:0] actData;
    logic               actValid;
    logic               actLast;
    logic               actReady;

    modport master (
        output expData, expValid, actData, actValid, actLast,
        input  expReady, actReady
    );

    modport slave (
        input  expData, expValid, actData, actValid, actLast,
        output expReady, actReady
    );
endinterface

// File: rtl/round_trip_page_checker.sv
// Compares an original page with its compress/decompress round trip; verdict and stats appear one cycle after the last beat.
// Both streams stall together: a beat moves only when both sides are valid, and never outside RUN.
module round_trip_page_checker #(
    parameter int LANES          = 1,
    parameter int PAGE_BYTES     = 4096,
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int COUNT_W        = $clog2(PAGE_BYTES + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    round_trip_page_checker_if.slave    pageIf,
    output logic [COUNT_W-1:0]          matchCount,
    output logic [COUNT_W-1:0]          firstMismatch,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic                        lengthError,
    output logic [15:0]                 pageCount
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [COUNT_W-1:0] idx;
    logic [WD_W-1:0]    wdog;

    logic               xfer;
    logic               lastBeat;
    logic               wdExpire;
    logic               anyMis;
    logic [COUNT_W-1:0] eqCount;
    logic [COUNT_W-1:0] misLane;
    logic [COUNT_W-1:0] newMatch;

    // Walk lanes high to low so the lowest mismatching lane is the one left in misLane.
    always_comb begin
        eqCount = '0;
        misLane = '0;
        anyMis  = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pageIf.expData[8*i +: 8] == pageIf.actData[8*i +: 8]) begin
                eqCount = eqCount + COUNT_W'(1);
            end else begin
                anyMis  = 1'b1;
                misLane = COUNT_W'(i);
            end
        end
    end

    assign xfer            = (state == RUN) && pageIf.expValid && pageIf.actValid;
    assign pageIf.expReady = xfer;
    assign pageIf.actReady = xfer;
    assign lastBeat        = (idx == COUNT_W'(PAGE_BYTES - LANES));
    assign newMatch        = matchCount + eqCount;
    // A transfer in the expiry cycle takes priority over the watchdog.
    assign wdExpire        = (wdog >= WD_W'(TIMEOUT_CYCLES - 1)) && !xfer;

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (matchCount == COUNT_W'(PAGE_BYTES)) && !timeout && !lengthError;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            wdog          <= '0;
            matchCount    <= '0;
            firstMismatch <= COUNT_W'(PAGE_BYTES);
            timeout       <= 1'b0;
            lengthError   <= 1'b0;
            pageCount     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        idx           <= '0;
                        wdog          <= '0;
                        matchCount    <= '0;
                        firstMismatch <= COUNT_W'(PAGE_BYTES);
                        timeout       <= 1'b0;
                        lengthError   <= 1'b0;
                    end
                end
                RUN: begin
                    wdog <= wdog + WD_W'(1);
                    if (xfer) begin
                        matchCount <= newMatch;
                        idx        <= idx + COUNT_W'(LANES);
                        if (anyMis && (firstMismatch == COUNT_W'(PAGE_BYTES))) begin
                            firstMismatch <= idx + misLane;
                        end
                        if (lastBeat) begin
                            state       <= DONE;
                            lengthError <= !pageIf.actLast;
                            if (pageIf.actLast && (newMatch == COUNT_W'(PAGE_BYTES))) begin
                                pageCount <= pageCount + 16'd1;
                            end
                        end else if (pageIf.actLast) begin
                            state       <= DONE;
                            lengthError <= 1'b1;
                        end
                    end else if (wdExpire) begin
                        state   <= DONE;
                        timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
